// File: rtl/pwm_bridge_if.sv
// Bus bundle for pwm_bridge: run/load controls and settings in, gate drives and status out.
// The fault/tripped pair exists only when PWM_FAULT_EN is defined.
interface pwm_bridge_if #(
   parameter int CH   = 2,
   parameter int W    = 10,
   parameter int DT_W = 4
);
   logic              en;
   logic              load;
   logic [W-1:0]      period;
   logic [CH*W-1:0]   duty;
   logic [DT_W-1:0]   dead;
   logic [CH-1:0]     hi;
   logic [CH-1:0]     lo;
   logic              busy;
   logic              period_start;
`ifdef PWM_FAULT_EN
   logic              fault;
   logic              tripped;

   modport master (
      output en, load, period, duty, dead, fault,
      input  hi, lo, busy, period_start, tripped
   );

   modport slave (
      input  en, load, period, duty, dead, fault,
      output hi, lo, busy, period_start, tripped
   );
`else
   modport master (
      output en, load, period, duty, dead,
      input  hi, lo, busy, period_start
   );

   modport slave (
      input  en, load, period, duty, dead,
      output hi, lo, busy, period_start
   );
`endif
endinterface

// File: rtl/pwm_bridge.sv
// pwm_bridge: multi-channel complementary PWM with shared dead time for half-bridge gate pairs.
// Settings are double-buffered (shadow -> active) and only switch at period boundaries;
// a stop request lets the running period finish so the gate stage never sees a runt pulse.
// Optional macro PWM_FAULT_EN adds a fault input that trips the block into IDLE with a
// sticky tripped flag.
module pwm_bridge #(
   parameter int CH   = 2,
   parameter int W    = 10,
   parameter int DT_W = 4
) (
   input logic        clk,
   input logic        rst,
   pwm_bridge_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [W-1:0]      cnt;
   logic [W-1:0]      per_s;
   logic [W-1:0]      per_a;
   logic [W-1:0]      duty_s [CH];
   logic [W-1:0]      duty_a [CH];
   logic [DT_W-1:0]   dead_s;
   logic [DT_W-1:0]   dead_a;
   logic              pending;
   logic              first;
   logic [CH-1:0]     raw;
   logic [CH-1:0]     raw_q;
   logic [DT_W-1:0]   dtc [CH];
   logic [DT_W-1:0]   dtc_next [CH];
   logic [CH-1:0]     hi_q;
   logic [CH-1:0]     lo_q;
   logic [CH-1:0]     hi_next;
   logic [CH-1:0]     lo_next;
   logic              ps_q;
   logic              wrap;
   logic              start;
   logic              copy;
   logic              run_next;
   logic [W-1:0]      cnt_next;
   logic [W-1:0]      per_clamped;
   logic              fault_in;
   logic              tripped;

`ifdef PWM_FAULT_EN
   assign fault_in    = bus.fault;
   assign bus.tripped = tripped;

   // Sticky trip flag: set by any fault, released only once the run request is withdrawn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tripped <= 1'b0;
      end else if (fault_in) begin
         tripped <= 1'b1;
      end else if (!bus.en) begin
         tripped <= 1'b0;
      end
   end
`else
   assign fault_in = 1'b0;
   assign tripped  = 1'b0;
`endif

   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.busy         = (state == RUN);
   assign bus.period_start = ps_q;

   // Sequencing decisions: period wrap, start from IDLE, when to copy shadow settings, next count.
   always_comb begin
      per_clamped = (per_s < W'(2)) ? W'(2) : per_s;
      wrap        = (cnt == per_a - W'(1));
      start       = (state == IDLE) && bus.en && !tripped;
      copy        = start || ((state == RUN) && wrap && bus.en && pending);
      if (fault_in) begin
         run_next = 1'b0;
      end else if (state == RUN) begin
         run_next = !(wrap && !bus.en);
      end else begin
         run_next = start;
      end
      cnt_next = ((state == RUN) && run_next && !wrap) ? cnt + W'(1) : '0;
   end

   // Per-channel raw phase, dead-time countdown and the gate values to register.
   always_comb begin
      raw     = '0;
      hi_next = '0;
      lo_next = '0;
      for (int i = 0; i < CH; i++) begin
         dtc_next[i] = '0;
      end
      for (int i = 0; i < CH; i++) begin
         raw[i] = (cnt < duty_a[i]);
         if (first || (raw[i] != raw_q[i])) begin
            dtc_next[i] = dead_a;
         end else if (dtc[i] != '0) begin
            dtc_next[i] = dtc[i] - DT_W'(1);
         end else begin
            dtc_next[i] = '0;
         end
         hi_next[i] = (state == RUN) && raw[i] && (dtc_next[i] == '0) && !fault_in;
         lo_next[i] = (state == RUN) && !raw[i] && (dtc_next[i] == '0) && !fault_in;
      end
   end

   // Shadow registers and pending flag; a load always wins over the clear from a copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_s   <= W'(2);
         dead_s  <= '0;
         pending <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            duty_s[i] <= '0;
         end
      end else if (bus.load) begin
         per_s   <= bus.period;
         dead_s  <= bus.dead;
         pending <= 1'b1;
         for (int i = 0; i < CH; i++) begin
            duty_s[i] <= bus.duty[i*W +: W];
         end
      end else if (copy && !fault_in) begin
         pending <= 1'b0;
      end
   end

   // Main IDLE/RUN machine with counter, active settings, dead-time state and registered gates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         per_a  <= W'(2);
         dead_a <= '0;
         first  <= 1'b0;
         raw_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         ps_q   <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            duty_a[i] <= '0;
            dtc[i]    <= '0;
         end
      end else begin
         state <= run_next ? RUN : IDLE;
         cnt   <= cnt_next;
         first <= start && !fault_in;
         raw_q <= raw;
         hi_q  <= hi_next;
         lo_q  <= lo_next;
         ps_q  <= run_next && (cnt_next == '0);
         for (int i = 0; i < CH; i++) begin
            dtc[i] <= dtc_next[i];
         end
         if (copy && !fault_in) begin
            per_a  <= per_clamped;
            dead_a <= dead_s;
            for (int i = 0; i < CH; i++) begin
               duty_a[i] <= duty_s[i];
            end
         end
      end
   end

endmodule

// File: doc/pwm_bridge.md
Name: pwm_bridge

Overview:
- Multi-channel PWM generator for driving half-bridge gate pairs.
- Supports runtime-programmable period, per-channel duty and a shared dead time.
- Complementary hi/lo outputs per channel, with dead-time insertion on every transition.
- New settings are double-buffered and applied only at period boundaries; disabling finishes the current period before stopping (glitch-free start/stop for the gate-drive stage).

Parameters:
- CH, 2: number of channels (1..8).
- W, 10: counter/period/duty width in bits.
- DT_W, 4: dead-time width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run request (level).
- load  in  1  single-cycle strobe that captures period/duty/dead into shadow registers.
- period  in  W  period in clk cycles.
- duty  in  CH*W  per-channel high time in cycles; channel i occupies bits [i*W +: W].
- dead  in  DT_W  dead time in cycles.
- hi  out  CH  high-side gate, registered.
- lo  out  CH  low-side gate, registered.
- busy  out  1  high in RUN.
- period_start  out  1  one-cycle pulse on each cycle where cnt==0 in RUN.

Behaviour:
- Reset state:
  - State IDLE; cnt=0.
  - Shadow and active registers: period=2, duty=0, dead=0; pending=0.
  - Outputs: hi=0, lo=0, busy=0, period_start=0.
- load:
  - Captures inputs into shadow registers and sets pending=1, in any state.
  - A load coincident with the active-register copy: the new values go to shadow and pending stays 1.
- Period clamp: when copied to active, period<2 becomes 2.
- IDLE:
  - hi=lo=0; cnt held at 0.
  - On en=1: copy shadow to active, clear pending, cnt=0, go RUN.
- RUN:
  - cnt increments each cycle, 0..per_a-1.
  - At cnt==per_a-1:
    - en=0: go IDLE, and hi=lo=0 from the next cycle.
    - en=1: cnt=0; if pending, copy shadow to active and clear pending. The new values take effect from cnt=0.
- Raw phase: raw[i] = (cnt < duty_a[i]).
  - duty_a[i]=0 gives lo for the full period.
  - duty_a[i]>=per_a gives hi for the full period, with no transitions and hence no dead time.
- Dead time:
  - Per-channel counter dtc[i], DT_W bits.
  - Loaded with dead_a when raw[i] differs from its previous-cycle value, and on the first RUN cycle. Otherwise it decrements to 0 and saturates there.
  - Outputs are registered: hi[i] <= RUN & raw[i] & (next dtc[i]==0); lo[i] <= RUN & !raw[i] & (next dtc[i]==0).
  - Latency: outputs lag cnt by 1 cycle.
  - dead_a=0: pure complementary, no gap.
- Invariant: hi[i] and lo[i] are never both 1, in any cycle, including reset and mid-period reconfiguration.
- Async reset mid-period: all outputs 0 immediately, state IDLE.
- en toggling within a period has no effect except the sample taken at the period end.

Optional Feature:
- Macro PWM_FAULT_EN.
- Defined: adds ports fault (in, 1) and tripped (out, 1).
  - fault=1 in any cycle forces hi=lo=0 on the next edge, sets tripped, and puts the block in IDLE.
  - tripped is sticky; while tripped=1, IDLE ignores en.
  - tripped clears only on a cycle with en=0 and fault=0, or on rst.
- Undefined: no fault/tripped ports; behaviour exactly as above.

Test Plan:
- Reset, then load period=10, duty=4/7, dead=2, en=1 -> ch0 per period: hi 2 cycles (cnt 2..3), dead 2 cycles, lo 4 cycles (cnt 6..9); ch1: hi 5, lo 1; period_start every 10 cycles; never hi&lo.
- While running, load period=20, duty=10/10, dead=3 at cnt=5 -> old settings hold until cnt=9; new settings apply from the next cnt=0; no output glitch.
- Duty edge cases: duty=0 -> lo constant after the initial dead gap; duty=10 with period=10 -> hi constant, no gaps across boundaries; period=0 -> behaves as period=2.
- Drop en at cnt=3 -> period completes through cnt=9, then hi=lo=0, busy=0; re-raise en -> initial dead gap of dead cycles before the first active gate.
- Assert rst asynchronously mid-period -> hi=lo=0 before the next clk edge; after release, IDLE with settings at reset defaults.
- PWM_FAULT_EN: pulse fault at cnt=4 -> outputs 0 the next cycle, tripped=1; en held high -> stays IDLE; en=0 then en=1 -> restarts.
